spi_cmd_rx: RTL and testbench
=============================

// Module: spi_cmd_rx
// PURPOSE
// SPI-slave front end that feeds control_unit. Samples the host MCU's SPI
// bus in the clk domain and buffers received bytes in a show-ahead FIFO.
// Presents the FIFO head to control_unit as in_byte/in_ready and pops on its next pulse.
// Returns a status byte to the host on MISO.
// PARAMETERS
// FIFO_DEPTH   16  byte FIFO entries; power of 2, >=2
// SYNC_STAGES  2   flops in sck/mosi/cs_n input synchronisers, >=2
// PORTS
// clk           in   1  system clock
// reset         in   1  asynchronous, active-low reset
// spi_sck       in   1  SPI clock, mode 0 (CPOL=0, CPHA=0); async to clk
// spi_mosi      in   1  SPI data in, MSB first
// spi_cs_n      in   1  SPI chip select, active-low
// spi_miso      out  1  SPI data out, MSB first
// ctrl_ready    in   1  control_unit is in its READY state
// in_byte       out  8  FIFO head byte; to control_unit.in_byte
// in_ready      out  1  FIFO non-empty; to control_unit.in_ready
// next          in   1  one-cycle pop strobe from control_unit.next
// clear_ovf     in   1  clears overflow sticky
// overflow      out  1  sticky: a received byte was dropped because the FIFO was full
// fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset (reset==0, asynchronous): outputs in_ready=0, in_byte=0, spi_miso=0, overflow=0, fifo_level=0.
//   Internal state: synchronisers all reset to sck=0, mosi=0, cs_n=1; bit_cnt=0; pointers=0.
// - Rise and fall edges are detected on the synchronised sck, one cycle after the last sync stage.
// - Clock ratio: f_clk >= 8*f_sck is required. Slower clk is unsupported (edges are lost).
// - Synchronised cs_n==1: bit_cnt held at 0 and rx shift register cleared. SCK edges are ignored.
// - cs_n rising mid-byte (bit_cnt!=0): the partial byte is discarded. Nothing is pushed.
// - Rise edge with cs_n==0: rx <= {rx[6:0],mosi}; bit_cnt <= bit_cnt+1 (mod 8).
//   On the 8th rise, the byte completes. push=1 in the same cycle; data is written to the FIFO
//   on the next clk edge. in_ready rises 1 cycle after the completing rise edge is detected.
// - Push while full, no pop in that cycle: the byte is dropped and overflow is set to 1.
// - overflow: cleared only by clear_ovf. If set and clear happen in the same cycle, set wins.
// - Pop: next==1 && in_ready==1 advances the read pointer. next==1 while empty is ignored.
// - Push and pop in the same cycle: both take effect and the level is unchanged.
//   This holds when full; the full check applies to post-pop occupancy.
// - in_byte is the show-ahead head. It is stable while in_ready==1 and next==0.
//   After a pop, in_byte shows the new head on the following cycle. in_byte is not cleared when empty.
// - fifo_level: registered; 0..FIFO_DEPTH; wraps never. Pointers are $clog2(FIFO_DEPTH) bits and wrap mod depth.
// - Status byte = {ctrl_ready, overflow, in_ready, sat5(fifo_level)}. It is captured into tx shift register:
//   (a) on the cycle the synchronised cs_n falling is detected; (b) on each byte-completing rise edge.
// - spi_miso drive:
//   at (a), spi_miso <= status[7];
//   on each fall edge with cs_n==0, spi_miso <= tx[7-bit_cnt], so the first fall after a byte completes drives the new bit 7.
//   While cs_n==1, spi_miso <= 0.
// - Status ordering: the host therefore reads during byte k the status sampled at the end of byte k-1, or at CS fall for k=0.
// - No backpressure to the host. The host must poll status or respect FIFO_DEPTH.
// TESTING
// 1 Reset mid-byte (4 bits shifted, reset low 1 cycle), then full byte 0xA5
//   -> after reset all outputs 0; exactly one byte 0xA5 is received, in_ready=1, fifo_level=1.
// 2 CS low, send 0x01,0x10,0x03, next held 0
//   -> in_byte=0x01, level=3; pop x3 -> in_byte 0x10, 0x03, then in_ready=0.
// 3 Send 17 bytes 0x00..0x10 with depth 16 and no pops
//   -> level=16, overflow=1, byte 0x10 lost. Popping 16 yields 0x00..0x0F in order.
// 4 FIFO full; the 17th byte completes in the same cycle as a next pulse
//   -> no drop, overflow stays 0, level stays 16, the last entry is the 17th byte.
// 5 Send 3 bits, raise CS, lower CS, send 0x7E
//   -> only 0x7E is pushed; the partial byte is discarded.
// 6 ctrl_ready=1, overflow=0, empty FIFO; CS falls, host clocks 0x00
//   -> MISO returns 0b10000000. With 2 queued bytes, the next byte returns 0b10100010 (ready, in_ready, level 2)
//      provided no pop has occurred.

Source files
------------

// File: rtl/spi_cmd_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_rx_if
// Description : Host SPI pins and control_unit byte handshake for spi_cmd_rx.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_cmd_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic               spi_sck;
    logic               spi_mosi;
    logic               spi_cs_n;
    logic               spi_miso;
    logic               ctrl_ready;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               next;
    logic               clear_ovf;
    logic               overflow;
    logic [c_lvl_w-1:0] fifo_level;

    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, ctrl_ready, next, clear_ovf,
        output spi_miso, in_byte, in_ready, overflow, fifo_level
    );

    modport master (
        output spi_sck, spi_mosi, spi_cs_n, ctrl_ready, next, clear_ovf,
        input  spi_miso, in_byte, in_ready, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_rx
// Description : Mode-0 SPI slave receiver with show-ahead byte FIFO and a
//               status byte returned on MISO.
// Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_cmd_rx_if.slave bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic                   w_sck;
    logic                   w_mosi;
    logic                   w_cs_n;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_fall;

    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx;
    logic [7:0]             r_tx;
    logic                   r_miso;
    logic                   w_byte_done;
    logic [7:0]             w_push_data;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_lvl_w-1:0]     r_level;
    logic                   r_overflow;

    logic                   w_in_ready;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_drop;
    logic [4:0]             w_lvl_sat;
    logic [7:0]             w_status;

    // Input synchronisers; idle values match a deselected mode-0 bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_fall  = ~w_cs_n & r_cs_d;

    assign w_byte_done = ~w_cs_n & w_sck_rise & (r_bit_cnt == 3'd7);
    assign w_push_data = {r_rx, w_mosi};

    // Deselect discards any partial byte by clearing the counter and shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
        end else if (w_cs_n) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
        end else if (w_sck_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_rx      <= {r_rx[5:0], w_mosi};
        end
    end

    assign w_in_ready = (r_level != '0);
    assign w_full     = (r_level == c_lvl_w'(FIFO_DEPTH));
    assign w_pop      = bus.next & w_in_ready;
    // Fullness is judged after a same-cycle pop frees a slot.
    assign w_wr_en    = w_byte_done & (~w_full | w_pop);
    assign w_drop     = w_byte_done & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + c_lvl_w'(1);
            end else if (!w_wr_en && w_pop) begin
                r_level <= r_level - c_lvl_w'(1);
            end
        end
    end

    // Sticky drop flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_lvl_sat = (32'(r_level) > 32'd31) ? 5'd31 : 5'(r_level);
    assign w_status  = {bus.ctrl_ready, r_overflow, w_in_ready, w_lvl_sat};

    // Bit 7 goes out at select so the host's first rising edge can sample it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx   <= 8'd0;
            r_miso <= 1'b0;
        end else if (w_cs_n) begin
            r_miso <= 1'b0;
        end else if (w_cs_fall) begin
            r_tx   <= w_status;
            r_miso <= w_status[7];
        end else begin
            if (w_byte_done) begin
                r_tx <= w_status;
            end
            if (w_sck_fall) begin
                r_miso <= r_tx[3'd7 - r_bit_cnt];
            end
        end
    end

    assign bus.spi_miso   = r_miso;
    assign bus.in_byte    = r_mem[r_rd_ptr];
    assign bus.in_ready   = w_in_ready;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = r_level;
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_rx
// Description : Directed self-checking bench for spi_cmd_rx.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_cmd_rx;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rx;

    spi_cmd_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    spi_cmd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift nbits of d MSB first; optionally pulse next in the push cycle of the last bit.
    task automatic spi_xfer(input logic [7:0] d, input int nbits, input bit pop_last,
                            output logic [7:0] rdata);
        rdata = 8'd0;
        for (int k = 0; k < nbits; k++) begin
            bus.spi_mosi = d[7-k];
            repeat (HALF) @(negedge clk);
            bus.spi_sck = 1'b1;
            rdata[7-k] = bus.spi_miso;
            if (pop_last && k == nbits - 1) begin
                repeat (SYNC) @(negedge clk);
                bus.next = 1'b1;
                @(negedge clk);
                bus.next = 1'b0;
                repeat (HALF - SYNC - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        logic [7:0] dummy;
        spi_xfer(d, 8, 1'b0, dummy);
    endtask

    task automatic pop();
        bus.next = 1'b1;
        @(negedge clk);
        bus.next = 1'b0;
    endtask

    task automatic cs_set(input logic v);
        bus.spi_cs_n = v;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        bus.spi_sck    = 1'b0;
        bus.spi_mosi   = 1'b0;
        bus.spi_cs_n   = 1'b1;
        bus.ctrl_ready = 1'b1;
        bus.next       = 1'b0;
        bus.clear_ovf  = 1'b0;
        reset          = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: reset in the middle of a byte, then one clean byte
        cs_set(1'b0);
        send(8'h3C);
        check("t1_pre_level", 32'(bus.fifo_level), 32'd1);
        check("t1_pre_byte", 32'(bus.in_byte), 32'h3C);
        spi_xfer(8'hF0, 4, 1'b0, rx);
        reset = 1'b0;
        #1;
        check("t1_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t1_rst_in_byte", 32'(bus.in_byte), 32'd0);
        check("t1_rst_miso", 32'(bus.spi_miso), 32'd0);
        check("t1_rst_overflow", 32'(bus.overflow), 32'd0);
        check("t1_rst_level", 32'(bus.fifo_level), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send(8'hA5);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        check("t1_level", 32'(bus.fifo_level), 32'd1);
        check("t1_byte", 32'(bus.in_byte), 32'hA5);
        pop();
        check("t1_empty", 32'(bus.in_ready), 32'd0);

        // 2: three bytes queued, drained in order
        send(8'h01);
        send(8'h10);
        send(8'h03);
        check("t2_head", 32'(bus.in_byte), 32'h01);
        check("t2_level", 32'(bus.fifo_level), 32'd3);
        pop();
        check("t2_pop1", 32'(bus.in_byte), 32'h10);
        pop();
        check("t2_pop2", 32'(bus.in_byte), 32'h03);
        check("t2_level1", 32'(bus.fifo_level), 32'd1);
        pop();
        check("t2_empty", 32'(bus.in_ready), 32'd0);
        check("t2_level0", 32'(bus.fifo_level), 32'd0);

        // 3: overflow on the 17th byte
        for (int b = 0; b <= 16; b++) send(8'(b));
        check("t3_level", 32'(bus.fifo_level), 32'd16);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_byte%0d", i), 32'(bus.in_byte), 32'(i));
            pop();
        end
        check("t3_empty", 32'(bus.in_ready), 32'd0);
        check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clear_ovf = 1'b1;
        @(negedge clk);
        bus.clear_ovf = 1'b0;
        check("t3_ovf_clear", 32'(bus.overflow), 32'd0);

        // 4: push into a full FIFO in the same cycle as a pop
        for (int b = 0; b < 16; b++) send(8'h20 + 8'(b));
        check("t4_full", 32'(bus.fifo_level), 32'd16);
        spi_xfer(8'h55, 8, 1'b1, rx);
        check("t4_level", 32'(bus.fifo_level), 32'd16);
        check("t4_overflow", 32'(bus.overflow), 32'd0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("t4_byte%0d", j), 32'(bus.in_byte),
                  (j == 15) ? 32'h55 : 32'(8'h21 + 8'(j)));
            pop();
        end
        check("t4_empty", 32'(bus.in_ready), 32'd0);

        // 5: partial byte discarded on deselect
        spi_xfer(8'hE0, 3, 1'b0, rx);
        cs_set(1'b1);
        cs_set(1'b0);
        send(8'h7E);
        check("t5_level", 32'(bus.fifo_level), 32'd1);
        check("t5_byte", 32'(bus.in_byte), 32'h7E);
        pop();
        check("t5_empty", 32'(bus.fifo_level), 32'd0);

        // 6: status byte on MISO
        cs_set(1'b1);
        cs_set(1'b0);
        spi_xfer(8'h00, 8, 1'b0, rx);
        check("t6_status_empty", 32'(rx), 32'h80);
        send(8'h00);
        check("t6_level2", 32'(bus.fifo_level), 32'd2);
        cs_set(1'b1);
        check("t6_miso_idle", 32'(bus.spi_miso), 32'd0);
        cs_set(1'b0);
        spi_xfer(8'h00, 8, 1'b0, rx);
        check("t6_status_two", 32'(rx), 32'hA2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
